// File: rtl/tic_tac_toe_game.sv
// Tic-tac-toe referee: validates edge-detected player (X) / computer (O) move
// requests against turn order and board occupancy, stores moves, reports winner.
module tic_tac_toe_game (
   input  logic       clock,
   input  logic       reset,
   input  logic       play,
   input  logic       pc,
   input  logic [3:0] player_position,
   input  logic [3:0] computer_position,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [1:0] who
);

   typedef enum logic [1:0] {FIRST, P_TURN, C_TURN, OVER} state_t;

   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] CELL_X = 2'b01;
   localparam logic [1:0] CELL_O = 2'b10;

   state_t           state_q, state_d;
   logic [8:0][1:0]  board_q, board_d;
   logic [1:0]       who_q, who_d;
   logic             play_d_q, pc_d_q;

   logic p_fire, c_fire, p_ok, c_ok, x_win, o_win, full;

   function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] c);
      has_line = (b[0] == c && b[1] == c && b[2] == c) ||
                 (b[3] == c && b[4] == c && b[5] == c) ||
                 (b[6] == c && b[7] == c && b[8] == c) ||
                 (b[0] == c && b[3] == c && b[6] == c) ||
                 (b[1] == c && b[4] == c && b[7] == c) ||
                 (b[2] == c && b[5] == c && b[8] == c) ||
                 (b[0] == c && b[4] == c && b[8] == c) ||
                 (b[2] == c && b[4] == c && b[6] == c);
   endfunction

   always_comb begin
      p_fire = play & ~play_d_q;
      c_fire = pc & ~pc_d_q;
      p_ok   = (player_position <= 4'd8) && (board_q[player_position] == EMPTY);
      c_ok   = (computer_position <= 4'd8) && (board_q[computer_position] == EMPTY);
      x_win  = has_line(board_q, CELL_X);
      o_win  = has_line(board_q, CELL_O);
      full   = 1'b1;
      for (int unsigned i = 0; i < 9; i++) begin
         full = full & (board_q[i] != EMPTY);
      end
   end

   // Game-end detection runs on the registered board, so it takes priority over
   // any request arriving in the cycle after the deciding move.
   always_comb begin
      state_d = state_q;
      board_d = board_q;
      who_d   = who_q;
      if (state_q != OVER) begin
         if (x_win) begin
            who_d   = CELL_X;
            state_d = OVER;
         end else if (o_win) begin
            who_d   = CELL_O;
            state_d = OVER;
         end else if (full) begin
            state_d = OVER;
         end else if (p_fire && p_ok && state_q != C_TURN) begin
            board_d[player_position] = CELL_X;
            state_d = C_TURN;
         end else if (c_fire && c_ok && state_q != P_TURN) begin
            board_d[computer_position] = CELL_O;
            state_d = P_TURN;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= FIRST;
         board_q  <= '0;
         who_q    <= '0;
         play_d_q <= 1'b0;
         pc_d_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         who_q    <= who_d;
         play_d_q <= play;
         pc_d_q   <= pc;
      end
   end

   assign pos1 = board_q[0];
   assign pos2 = board_q[1];
   assign pos3 = board_q[2];
   assign pos4 = board_q[3];
   assign pos5 = board_q[4];
   assign pos6 = board_q[5];
   assign pos7 = board_q[6];
   assign pos8 = board_q[7];
   assign pos9 = board_q[8];
   assign who  = who_q;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Directed bench for tic_tac_toe_game: scripted games with hand-derived boards.
module tb_tic_tac_toe_game;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       play = 1'b0;
   logic       pc = 1'b0;
   logic [3:0] player_position = '0;
   logic [3:0] computer_position = '0;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;

   int errors = 0;
   int checks = 0;

   tic_tac_toe_game dut (
      .clock(clock), .reset(reset), .play(play), .pc(pc),
      .player_position(player_position), .computer_position(computer_position),
      .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
      .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .who(who)
   );

   always #5 clock = ~clock;

   // "XO.X....." style picture of the board, cell 1 first
   function automatic logic [17:0] bd(input string s);
      logic [17:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) begin
         if (s[i] == "X")      r[17-2*i -: 2] = 2'b01;
         else if (s[i] == "O") r[17-2*i -: 2] = 2'b10;
      end
      return r;
   endfunction

   function automatic logic [17:0] board();
      return {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
   endfunction

   task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_board(input string tag, input string s);
      chk(tag, board(), bd(s));
   endtask

   task automatic chk_who(input string tag, input logic [1:0] w);
      chk(tag, {16'b0, who}, {16'b0, w});
   endtask

   task automatic pmove(input logic [3:0] p);
      @(negedge clock);
      player_position = p;
      play = 1'b1;
      repeat (5) @(negedge clock);
      play = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic cmove(input logic [3:0] p);
      @(negedge clock);
      computer_position = p;
      pc = 1'b1;
      repeat (5) @(negedge clock);
      pc = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clock);
      chk_board("reset_board", ".........");
      chk_who("reset_who", 2'b00);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk_board("idle_board", ".........");
      chk_who("idle_who", 2'b00);

      // player wins on column 1-4-7, who lags the final write by one cycle
      pmove(0); cmove(2); pmove(1); cmove(4); pmove(3); cmove(8);
      chk_board("t2_pre", "XXOXO...O");
      @(negedge clock);
      player_position = 4'd6;
      play = 1'b1;
      @(negedge clock);
      chk_board("t2_final_write", "XXOXO.X.O");
      chk_who("t2_who_lag", 2'b00);
      @(negedge clock);
      chk_who("t2_who_win", 2'b01);
      repeat (3) @(negedge clock);
      play = 1'b0;
      cmove(5); pmove(7);
      chk_board("t2_lockout", "XXOXO.X.O");
      chk_who("t2_who_hold", 2'b01);

      // computer moves first and wins on column 1-4-7
      do_reset();
      chk_who("t3_reset_who", 2'b00);
      cmove(0); pmove(4); cmove(1); pmove(2); cmove(3); pmove(5); cmove(6);
      chk_board("t3_board", "OOXOXXO..");
      chk_who("t3_who", 2'b10);

      // anti-diagonal 3-5-7 win, then lockout
      do_reset();
      pmove(0); cmove(1); pmove(2); cmove(3); pmove(4); cmove(5); pmove(6);
      chk_who("t4_who", 2'b01);
      cmove(7); pmove(8);
      chk_board("t4_lockout", "XOXOXOX..");

      // draw
      do_reset();
      pmove(0); cmove(1); pmove(2); cmove(4); pmove(3); cmove(5); pmove(7); cmove(6); pmove(8);
      chk_board("t5_full", "XOXXOOOXX");
      chk_who("t5_who", 2'b00);
      cmove(0); pmove(1);
      chk_board("t5_after", "XOXXOOOXX");
      chk_who("t5_who_after", 2'b00);

      // illegal and out-of-turn requests
      do_reset();
      pmove(0);
      pmove(1);
      chk_board("t6_out_of_turn", "X........");
      cmove(0);
      chk_board("t6_occupied", "X........");
      cmove(9);
      chk_board("t6_range", "X........");
      cmove(1);
      chk_board("t6_accept", "XO.......");

      // a held play level writes once even after the turn comes back
      @(negedge clock);
      player_position = 4'd2;
      play = 1'b1;
      repeat (2) @(negedge clock);
      chk_board("t6_held_write", "XOX......");
      cmove(5);
      chk_board("t6_c_during_hold", "XOX..O...");
      player_position = 4'd6;
      repeat (3) @(negedge clock);
      chk_board("t6_held_no_rewrite", "XOX..O...");
      play = 1'b0;
      pmove(6);
      chk_board("t6_re_request", "XOX..OX..");

      // asynchronous reset mid-game, observed before any clock edge
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk_board("async_reset_board", ".........");
      chk_who("async_reset_who", 2'b00);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // simultaneous requests in FIRST: player has priority
      player_position = 4'd4;
      computer_position = 4'd0;
      play = 1'b1;
      pc = 1'b1;
      @(negedge clock);
      chk_board("prio_player", "....X....");
      repeat (2) @(negedge clock);
      play = 1'b0;
      pc = 1'b0;
      repeat (2) @(negedge clock);
      cmove(0);
      chk_board("prio_c_turn", "O...X....");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
